// File: rtl/dispatch_pkg.sv
// dispatch_pkg: FSM state encoding and channel constants for serial_dispatcher
package dispatch_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_GAP    = 2'd3
    } state_t;
    localparam logic [1:0] CH0 = 2'd0;
    localparam logic [1:0] CH1 = 2'd1;
    localparam logic [1:0] CH2 = 2'd2;
    localparam logic [1:0] CH3 = 2'd3;
endpackage

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: parallel-load, shift-right register; lsb is the next serial bit
module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             lsb
);
    logic [WIDTH-1:0] shreg_q, shreg_d;
    always_comb shreg_d = load ? din : shift ? shreg_q >> 1 : shreg_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) shreg_q <= '0;
        else shreg_q <= shreg_d;
    assign lsb = shreg_q[0];
endmodule

// File: rtl/serial_dispatcher.sv
// serial_dispatcher: valid/ready word in, LSB-first serial frame out to a 1-to-4 demux.
// Define DISPATCH_PARITY_EN to append an even-parity bit to every frame.
module serial_dispatcher
    import dispatch_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] Din,
    input  logic [1:0]       Dest,
    input  logic             Valid,
    output logic             Ready,
    output logic             Demux_In,
    output logic [1:0]       Demux_Sel,
    output logic             Busy,
    output logic             Done
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam state_t END_NEXT = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
`ifdef DISPATCH_PARITY_EN
    localparam state_t LAST_NEXT = ST_PARITY;
    logic par_q, par_d;
`else
    localparam state_t LAST_NEXT = END_NEXT;
`endif
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0] gap_q, gap_d;
    logic [1:0] sel_q, sel_d;
    logic in_q, in_d, busy_q, busy_d, done_q, done_d, ready_q, ready_d;
    logic accept, load, shift, ser, last;
    assign accept = Valid & ready_q;
    assign last = cnt_q == CW'(WIDTH - 1);
    piso_shift_reg #(.WIDTH(WIDTH)) u_shreg (
        .clk  (Clk),
        .rst  (Rst),
        .load (load),
        .shift(shift),
        .din  (Din),
        .lsb  (ser)
    );
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        sel_d   = sel_q;
        in_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        ready_d = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
`ifdef DISPATCH_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                ready_d = !accept;
                if (accept) begin
                    load    = 1'b1;
                    sel_d   = Dest;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
`ifdef DISPATCH_PARITY_EN
                    par_d   = ^Din;
`endif
                end
            end
            ST_SHIFT: begin
                in_d   = ser;
                busy_d = 1'b1;
                shift  = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (last) begin
                    state_d = LAST_NEXT;
                    done_d  = LAST_NEXT != ST_PARITY;
                    ready_d = LAST_NEXT == ST_IDLE;
                    gap_d   = '0;
                end
            end
`ifdef DISPATCH_PARITY_EN
            ST_PARITY: begin
                in_d    = par_q;
                busy_d  = 1'b1;
                done_d  = 1'b1;
                state_d = END_NEXT;
                ready_d = END_NEXT == ST_IDLE;
                gap_d   = '0;
            end
`endif
            ST_GAP: begin
                gap_d = gap_q + 4'd1;
                if (gap_q == 4'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            sel_q   <= '0;
            in_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
`ifdef DISPATCH_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            sel_q   <= sel_d;
            in_q    <= in_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
`ifdef DISPATCH_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end
    assign Ready     = ready_q;
    assign Demux_In  = in_q;
    assign Demux_Sel = sel_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
endmodule
